ale_frame_ctrl: RTL and testbench

Two-pass frame scheduler for the atmospheric light estimator (ALE) and the dehaze datapath. Pass 1 streams one frame of 3x3 windows into ALE and re-arms it per frame. Once the estimate settles, the block latches A and Inv_A. Pass 2 streams the same frame again into the transmission/recovery path with the latched values held constant. It sits between the frame-buffer window generator and both consumers.

---
 rtl/ale_frame_ctrl_if.sv | 42 ++++
 rtl/ale_frame_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_ale_frame_ctrl.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ale_frame_ctrl_if.sv
// rtl/ale_frame_ctrl_if.sv - window source, ALE and dehaze handshake bundle for ale_frame_ctrl
interface ale_frame_ctrl_if;
    logic        src_valid;
    logic        src_ready;
    logic        ale_valid;
    logic        ale_rst;
    logic        ale_done;
    logic [7:0]  A_R_in;
    logic [7:0]  A_G_in;
    logic [7:0]  A_B_in;
    logic [15:0] Inv_A_R_in;
    logic [15:0] Inv_A_G_in;
    logic [15:0] Inv_A_B_in;
    logic        dh_valid;
    logic        dh_ready;

    // controller side
    modport master (
        input  src_valid,
        output src_ready,
        output ale_valid,
        output ale_rst,
        input  ale_done,
        input  A_R_in, A_G_in, A_B_in,
        input  Inv_A_R_in, Inv_A_G_in, Inv_A_B_in,
        output dh_valid,
        input  dh_ready
    );

    // window source / ALE / dehaze side
    modport slave (
        output src_valid,
        input  src_ready,
        input  ale_valid,
        input  ale_rst,
        output ale_done,
        output A_R_in, A_G_in, A_B_in,
        output Inv_A_R_in, Inv_A_G_in, Inv_A_B_in,
        input  dh_valid,
        output dh_ready
    );
endinterface

// File: rtl/ale_frame_ctrl.sv
// rtl/ale_frame_ctrl.sv - two-pass ALE/dehaze frame scheduler; optional ALE_TEMPORAL_SMOOTH_EN averages latched A/Inv_A across frames
module ale_frame_ctrl #(
    parameter int IMG_W = 512,
    parameter int IMG_H = 512,
    parameter int DRAIN = 2,
    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1,
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    ale_frame_ctrl_if.master     bus,
    output logic [7:0]           A_R,
    output logic [7:0]           A_G,
    output logic [7:0]           A_B,
    output logic [15:0]          Inv_A_R,
    output logic [15:0]          Inv_A_G,
    output logic [15:0]          Inv_A_B,
    output logic                 params_valid,
    output logic [CW-1:0]        pix_col,
    output logic [RW-1:0]        pix_row,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 sync_err
);

    localparam int DW = $clog2(DRAIN + 1) + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_PASS1, S_DRAIN, S_LATCH, S_PASS2, S_DONE
    } state_t;

    state_t        state;
    state_t        state_n;
    logic [DW-1:0] drain_cnt;
    logic          src_ready_c;
    logic          ale_valid_c;
    logic          dh_valid_c;
    logic          xfer;
    logic          col_last;
    logic          row_last;
    logic          last_pix;

    assign col_last      = (pix_col == CW'(IMG_W - 1));
    assign row_last      = (pix_row == RW'(IMG_H - 1));
    assign last_pix      = col_last & row_last;
    assign xfer          = bus.src_valid & src_ready_c;
    assign bus.src_ready = src_ready_c;
    assign bus.ale_valid = ale_valid_c;
    assign bus.dh_valid  = dh_valid_c;
    assign busy          = (state != S_IDLE) && (state != S_DONE);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_n;
    end

    // Next-state and handshake decode; ALE never stalls, so pass 1 is always ready
    always_comb begin
        state_n     = state;
        src_ready_c = 1'b0;
        ale_valid_c = 1'b0;
        dh_valid_c  = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) state_n = S_CLEAR;
            end
            S_CLEAR: state_n = S_PASS1;
            S_PASS1: begin
                src_ready_c = 1'b1;
                ale_valid_c = bus.src_valid;
                if (bus.src_valid && last_pix)
                    state_n = (DRAIN == 0) ? S_LATCH : S_DRAIN;
            end
            S_DRAIN: begin
                if (drain_cnt == DW'(DRAIN - 1)) state_n = S_LATCH;
            end
            S_LATCH: state_n = S_PASS2;
            S_PASS2: begin
                src_ready_c = bus.dh_ready;
                dh_valid_c  = bus.src_valid;
                if (bus.src_valid && bus.dh_ready && last_pix) state_n = S_DONE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Drain wait counter: counts cycles spent in DRAIN so the last ALE update lands before LATCH
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                  drain_cnt <= '0;
        else if (state == S_DRAIN) drain_cnt <= drain_cnt + 1'b1;
        else                       drain_cnt <= '0;
    end

    // Pixel counters: zeroed in CLEAR and LATCH so both passes start at (0,0); they stall without a transfer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pix_col <= '0;
            pix_row <= '0;
        end else if (state == S_CLEAR || state == S_LATCH) begin
            pix_col <= '0;
            pix_row <= '0;
        end else if (xfer) begin
            if (col_last) begin
                pix_col <= '0;
                pix_row <= row_last ? '0 : pix_row + 1'b1;
            end else begin
                pix_col <= pix_col + 1'b1;
            end
        end
    end

    // Control flags: ale_rst mirrors entry into CLEAR, sync_err is sticky until reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.ale_rst  <= 1'b1;
            params_valid <= 1'b0;
            frame_done   <= 1'b0;
            sync_err     <= 1'b0;
        end else begin
            bus.ale_rst <= (state_n == S_CLEAR);
            frame_done  <= (state == S_PASS2) && xfer && last_pix;
            if (state_n == S_CLEAR)     params_valid <= 1'b0;
            else if (state == S_LATCH)  params_valid <= 1'b1;
            if (state == S_LATCH && !bus.ale_done) sync_err <= 1'b1;
        end
    end

`ifdef ALE_TEMPORAL_SMOOTH_EN
    logic have_prev;

    function automatic logic [7:0] avg8(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b} + 9'd1;
        return s[8:1];
    endfunction

    function automatic logic [15:0] avg16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b} + 17'd1;
        return s[16:1];
    endfunction

    // Parameter latch with 1-tap IIR; the first frame after reset has no history and stores raw values
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            have_prev <= 1'b0;
            A_R <= '0; A_G <= '0; A_B <= '0;
            Inv_A_R <= '0; Inv_A_G <= '0; Inv_A_B <= '0;
        end else if (state == S_LATCH) begin
            have_prev <= 1'b1;
            if (have_prev) begin
                A_R     <= avg8(A_R, bus.A_R_in);
                A_G     <= avg8(A_G, bus.A_G_in);
                A_B     <= avg8(A_B, bus.A_B_in);
                Inv_A_R <= avg16(Inv_A_R, bus.Inv_A_R_in);
                Inv_A_G <= avg16(Inv_A_G, bus.Inv_A_G_in);
                Inv_A_B <= avg16(Inv_A_B, bus.Inv_A_B_in);
            end else begin
                A_R     <= bus.A_R_in;
                A_G     <= bus.A_G_in;
                A_B     <= bus.A_B_in;
                Inv_A_R <= bus.Inv_A_R_in;
                Inv_A_G <= bus.Inv_A_G_in;
                Inv_A_B <= bus.Inv_A_B_in;
            end
        end
    end
`else
    // Parameter latch: raw ALE values captured once per frame and held through pass 2 and DONE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            A_R <= '0; A_G <= '0; A_B <= '0;
            Inv_A_R <= '0; Inv_A_G <= '0; Inv_A_B <= '0;
        end else if (state == S_LATCH) begin
            A_R     <= bus.A_R_in;
            A_G     <= bus.A_G_in;
            A_B     <= bus.A_B_in;
            Inv_A_R <= bus.Inv_A_R_in;
            Inv_A_G <= bus.Inv_A_G_in;
            Inv_A_B <= bus.Inv_A_B_in;
        end
    end
`endif

endmodule

// File: tb/tb_ale_frame_ctrl.sv
// tb/tb_ale_frame_ctrl.sv - self-checking bench for ale_frame_ctrl with a frame-level reference model
module tb_ale_frame_ctrl;
    localparam int W  = 4;
    localparam int H  = 4;
    localparam int DR = 2;
    localparam int N  = W * H;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic [7:0]  A_R, A_G, A_B;
    logic [15:0] Inv_A_R, Inv_A_G, Inv_A_B;
    logic        params_valid, busy, frame_done, sync_err;
    logic [1:0]  pix_col, pix_row;

    int total = 0;
    int bad = 0;

    int  e_a[3];
    int  e_i[3];
    bit  m_have;
    bit  m_err;

    always #5 clk = ~clk;

    ale_frame_ctrl_if bus();

    ale_frame_ctrl #(.IMG_W(W), .IMG_H(H), .DRAIN(DR)) dut (
        .clk(clk), .rst(rst), .start(start), .bus(bus),
        .A_R(A_R), .A_G(A_G), .A_B(A_B),
        .Inv_A_R(Inv_A_R), .Inv_A_G(Inv_A_G), .Inv_A_B(Inv_A_B),
        .params_valid(params_valid), .pix_col(pix_col), .pix_row(pix_row),
        .busy(busy), .frame_done(frame_done), .sync_err(sync_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            e_a[i] = 0;
            e_i[i] = 0;
        end
        m_have = 1'b0;
        m_err  = 1'b0;
    endtask

    // Frame-level model of what LATCH should leave on the outputs
    task automatic model_latch(input int na[3], input int ni[3], input bit done_v);
        for (int i = 0; i < 3; i++) begin
`ifdef ALE_TEMPORAL_SMOOTH_EN
            if (m_have) begin
                e_a[i] = (e_a[i] + na[i] + 1) / 2;
                e_i[i] = (e_i[i] + ni[i] + 1) / 2;
            end else begin
                e_a[i] = na[i];
                e_i[i] = ni[i];
            end
`else
            e_a[i] = na[i];
            e_i[i] = ni[i];
`endif
        end
        m_have = 1'b1;
        if (!done_v) m_err = 1'b1;
    endtask

    task automatic chk_lat(input string tag);
        chk({tag, "_A_R"}, A_R, e_a[0]);
        chk({tag, "_A_G"}, A_G, e_a[1]);
        chk({tag, "_A_B"}, A_B, e_a[2]);
        chk({tag, "_Inv_R"}, Inv_A_R, e_i[0]);
        chk({tag, "_Inv_G"}, Inv_A_G, e_i[1]);
        chk({tag, "_Inv_B"}, Inv_A_B, e_i[2]);
        chk({tag, "_sync_err"}, sync_err, m_err);
    endtask

    // One full frame; returns in the cycle where frame_done should be high.
    // p1_mode: 0 continuous, 1 random valid.  p2_mode: 0 always ready, 1 ready toggling 1,0,..., 2 random.
    task automatic run_frame(input int na[3], input int ni[3], input bit done_v,
                             input int p1_mode, input int p2_mode, input bit start_p1);
        int k;
        int cyc;
        bit sv;
        bit dr;
        bus.A_R_in = 8'(na[0]); bus.A_G_in = 8'(na[1]); bus.A_B_in = 8'(na[2]);
        bus.Inv_A_R_in = 16'(ni[0]); bus.Inv_A_G_in = 16'(ni[1]); bus.Inv_A_B_in = 16'(ni[2]);
        bus.ale_done = done_v;
        bus.src_valid = 1'b0;
        bus.dh_ready = 1'b0;
        start = 1'b1;
        #1;
        chk("start_not_busy", busy, 0);
        nxt();
        start = 1'b0;
        #1;
        chk("clr_ale_rst", bus.ale_rst, 1);
        chk("clr_params", params_valid, 0);
        chk("clr_src_ready", bus.src_ready, 0);
        chk("clr_busy", busy, 1);
        chk("clr_col", pix_col, 0);
        nxt();
        k = 0;
        cyc = 0;
        while (k < N && cyc < 200) begin
            sv = (p1_mode == 0) ? 1'b1 : 1'($urandom_range(1));
            bus.src_valid = sv;
            start = start_p1 && (cyc == 3);
            #1;
            chk("p1_src_ready", bus.src_ready, 1);
            chk("p1_ale_valid", bus.ale_valid, sv);
            chk("p1_dh_valid", bus.dh_valid, 0);
            chk("p1_ale_rst", bus.ale_rst, 0);
            chk("p1_col", pix_col, k % W);
            chk("p1_row", pix_row, k / W);
            if (sv) k++;
            nxt();
            cyc++;
        end
        start = 1'b0;
        chk("p1_beats", k, N);
        if (p1_mode == 0) chk("p1_ale_valid_cycles", cyc, N);
        for (int i = 0; i < DR + 1; i++) begin
            bus.src_valid = 1'($urandom_range(1));
            #1;
            chk("dr_src_ready", bus.src_ready, 0);
            chk("dr_ale_valid", bus.ale_valid, 0);
            chk("dr_dh_valid", bus.dh_valid, 0);
            chk("dr_params", params_valid, 0);
            chk("dr_busy", busy, 1);
            nxt();
        end
        model_latch(na, ni, done_v);
        bus.A_R_in = 8'($urandom); bus.A_G_in = 8'($urandom); bus.A_B_in = 8'($urandom);
        bus.Inv_A_R_in = 16'($urandom); bus.Inv_A_G_in = 16'($urandom);
        bus.Inv_A_B_in = 16'($urandom);
        bus.ale_done = 1'($urandom_range(1));
        #1;
        chk("p2_params", params_valid, 1);
        chk_lat("p2_entry");
        k = 0;
        cyc = 0;
        while (k < N && cyc < 300) begin
            sv = (p2_mode == 2) ? 1'($urandom_range(1)) : 1'b1;
            if (p2_mode == 0)      dr = 1'b1;
            else if (p2_mode == 1) dr = (cyc % 2 == 0);
            else                   dr = 1'($urandom_range(1));
            bus.src_valid = sv;
            bus.dh_ready = dr;
            #1;
            chk("p2_src_ready", bus.src_ready, dr);
            chk("p2_dh_valid", bus.dh_valid, sv);
            chk("p2_ale_valid", bus.ale_valid, 0);
            chk("p2_col", pix_col, k % W);
            chk("p2_row", pix_row, k / W);
            chk("p2_frame_done", frame_done, 0);
            if (sv && dr) k++;
            nxt();
            cyc++;
        end
        chk("p2_beats", k, N);
        if (p2_mode == 0) chk("p2_cycles", cyc, N);
        if (p2_mode == 1) chk("p2_toggle_cycles", cyc, 2 * N - 1);
        bus.src_valid = 1'b0;
        bus.dh_ready = 1'b0;
        #1;
        chk("done_frame_done", frame_done, 1);
        chk("done_busy", busy, 0);
        chk("done_params", params_valid, 1);
        chk("done_src_ready", bus.src_ready, 0);
        chk_lat("done");
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            nxt();
            #1;
            chk("idle_frame_done", frame_done, 0);
            chk("idle_busy", busy, 0);
            chk("idle_params", params_valid, 1);
            chk_lat("idle");
        end
    endtask

    task automatic rand_vals(output int na[3], output int ni[3]);
        for (int i = 0; i < 3; i++) begin
            na[i] = int'($urandom_range(255));
            ni[i] = int'($urandom_range(65535));
        end
    endtask

    initial begin
        int na[3];
        int ni[3];
        model_reset();
        bus.src_valid = 1'b0;
        bus.dh_ready = 1'b0;
        bus.ale_done = 1'b0;
        bus.A_R_in = '0; bus.A_G_in = '0; bus.A_B_in = '0;
        bus.Inv_A_R_in = '0; bus.Inv_A_G_in = '0; bus.Inv_A_B_in = '0;

        // reset state
        #12;
        chk("rst_ale_rst", bus.ale_rst, 1);
        chk("rst_busy", busy, 0);
        chk("rst_src_ready", bus.src_ready, 0);
        chk("rst_params", params_valid, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_pix", {pix_row, pix_col}, 0);
        chk_lat("rst");
        nxt();
        rst = 1'b1;
        #1;
        chk("rel_ale_rst_held", bus.ale_rst, 1);
        nxt();
        chk("rel_ale_rst_drop", bus.ale_rst, 0);
        chk("rel_busy", busy, 0);
        chk("rel_ale_valid", bus.ale_valid, 0);
        chk("rel_dh_valid", bus.dh_valid, 0);
        chk_lat("rel");

        // frame 1: reference values, continuous streaming
        na = '{200, 180, 160};
        ni = '{328, 364, 410};
        run_frame(na, ni, 1'b1, 0, 0, 1'b0);
        idle(3);

        // frame 2: A_R=101, random pass-1 gaps, dh_ready toggling, start ignored in pass 1
        rand_vals(na, ni);
        na[0] = 101;
        run_frame(na, ni, 1'b1, 1, 1, 1'b1);

        // frame 3 starts on the frame_done cycle; ALE reports not done -> sticky sync_err
        rand_vals(na, ni);
        run_frame(na, ni, 1'b0, 1, 2, 1'b0);
        idle(1);

        // frame 4: sync_err must remain set
        rand_vals(na, ni);
        run_frame(na, ni, 1'b1, 1, 2, 1'b0);
        idle(2);

        // reset in the middle of pass 1 aborts and drops latched values
        start = 1'b1;
        nxt();
        start = 1'b0;
        nxt();
        bus.src_valid = 1'b1;
        nxt();
        nxt();
        rst = 1'b0;
        #1;
        model_reset();
        chk("abort_busy", busy, 0);
        chk("abort_ale_rst", bus.ale_rst, 1);
        chk("abort_params", params_valid, 0);
        chk("abort_src_ready", bus.src_ready, 0);
        chk("abort_pix", {pix_row, pix_col}, 0);
        chk_lat("abort");
        bus.src_valid = 1'b0;
        nxt();
        rst = 1'b1;
        nxt();
        chk("abort_rel_ale_rst", bus.ale_rst, 0);

        // frame 5: first frame after reset stores raw values again
        rand_vals(na, ni);
        run_frame(na, ni, 1'b1, 0, 2, 1'b0);
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
